// File: rtl/nabp_swap_control.sv
// nabp_swap_control
//   Upstream controller for a ping-pong pair of NABPProcessingSwappable units
//   (A and B). It steps the projection-angle counter, reads the per-angle
//   accumulator bases from a registered LUT, hands them to whichever unit
//   asks via next_itr, acknowledges swap requests in lock-step and forwards
//   the shifting unit's PE enable/taps to the PE array.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   kick                         start one pass (only looked at in IDLE)
//   done                         1-cycle pulse at the end of a pass
//   lut_angle                    angle address to the accumulator LUT
//   lut_sh/mp_accu_*             LUT data, valid one cycle after lut_angle
//   {a,b}_sw_swap                unit phase finished, held until swap_ack
//   {a,b}_sw_next_itr            unit wants next-angle bases, held until ack
//   {a,b}_sw_pe_en, {a,b}_pe_taps  unit PE enable/taps
//   {a,b}_sh/mp_accu_*           registered bases per unit
//   {a,b}_swap_ack               1-cycle swap acknowledge
//   {a,b}_next_itr_ack           1-cycle acknowledge, bases valid same cycle
//   pe_en, pe_taps               selected unit's PE signals, registered
module nabp_swap_control #(
  parameter int unsigned NO_OF_ANGLES = 180,
  parameter int unsigned ANGLE_W      = 8,
  parameter int unsigned SH_W         = 16,
  parameter int unsigned MI_W         = 16,
  parameter int unsigned MB_W         = 16,
  parameter int unsigned TAPS_W       = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              kick,
  output logic              done,
  output logic [ANGLE_W-1:0] lut_angle,
  input  logic [SH_W-1:0]   lut_sh_accu_base,
  input  logic [MI_W-1:0]   lut_mp_accu_init,
  input  logic [MB_W-1:0]   lut_mp_accu_base,
  input  logic              a_sw_swap,
  input  logic              b_sw_swap,
  input  logic              a_sw_next_itr,
  input  logic              b_sw_next_itr,
  input  logic              a_sw_pe_en,
  input  logic              b_sw_pe_en,
  input  logic [TAPS_W-1:0] a_pe_taps,
  input  logic [TAPS_W-1:0] b_pe_taps,
  output logic [SH_W-1:0]   a_sh_accu_base,
  output logic [MI_W-1:0]   a_mp_accu_init,
  output logic [MB_W-1:0]   a_mp_accu_base,
  output logic [SH_W-1:0]   b_sh_accu_base,
  output logic [MI_W-1:0]   b_mp_accu_init,
  output logic [MB_W-1:0]   b_mp_accu_base,
  output logic              a_swap_ack,
  output logic              b_swap_ack,
  output logic              a_next_itr_ack,
  output logic              b_next_itr_ack,
  output logic              pe_en,
  output logic [TAPS_W-1:0] pe_taps
);

  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(NO_OF_ANGLES);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LUT_RD,
    NEXT_ACK,
    SWAP_ACK,
    DONE
  } state_t;

  state_t             state;
  logic [ANGLE_W-1:0] angle_cnt;
  logic               drained_a;
  logic               drained_b;
  logic               pe_sel;     // 0: unit A shifts, 1: unit B shifts
  logic               req_is_b;   // requester latched for LUT_RD/NEXT_ACK

  logic a_req;
  logic b_req;
  logic swap_ok;
  logic angles_left;
  logic sel_pe_en;
  logic idle_next;

  // A drained unit's held next_itr is never acked, so it is masked here;
  // otherwise it would starve the other unit and the pass could not end.
  assign a_req       = a_sw_next_itr & ~drained_a;
  assign b_req       = b_sw_next_itr & ~drained_b;
  assign swap_ok     = (a_sw_swap | drained_a) & (b_sw_swap | drained_b) &
                       (a_sw_swap | b_sw_swap);
  assign angles_left = angle_cnt < LAST_ANGLE;
  assign sel_pe_en   = pe_sel ? b_sw_pe_en : a_sw_pe_en;
  // pe_en is registered, so it is cleared on the way into IDLE to read 0
  // for every cycle the FSM sits in IDLE.
  assign idle_next   = (state == DONE) | ((state == IDLE) & ~kick);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      angle_cnt      <= '0;
      drained_a      <= 1'b0;
      drained_b      <= 1'b0;
      pe_sel         <= 1'b1;
      req_is_b       <= 1'b0;
      done           <= 1'b0;
      lut_angle      <= '0;
      a_sh_accu_base <= '0;
      a_mp_accu_init <= '0;
      a_mp_accu_base <= '0;
      b_sh_accu_base <= '0;
      b_mp_accu_init <= '0;
      b_mp_accu_base <= '0;
      a_swap_ack     <= 1'b0;
      b_swap_ack     <= 1'b0;
      a_next_itr_ack <= 1'b0;
      b_next_itr_ack <= 1'b0;
      pe_en          <= 1'b0;
      pe_taps        <= '0;
    end else begin
      done           <= 1'b0;
      a_swap_ack     <= 1'b0;
      b_swap_ack     <= 1'b0;
      a_next_itr_ack <= 1'b0;
      b_next_itr_ack <= 1'b0;
      pe_en          <= sel_pe_en & ~idle_next;
      pe_taps        <= pe_sel ? b_pe_taps : a_pe_taps;

      case (state)
        IDLE: begin
          if (kick) begin
            angle_cnt <= '0;
            lut_angle <= '0;
            drained_a <= 1'b0;
            drained_b <= 1'b0;
            pe_sel    <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          if (swap_ok) begin
            a_swap_ack <= a_sw_swap;
            b_swap_ack <= b_sw_swap;
            pe_sel     <= ~pe_sel;
            state      <= SWAP_ACK;
          end else if (a_req) begin
            if (angles_left) begin
              lut_angle <= angle_cnt;
              req_is_b  <= 1'b0;
              state     <= LUT_RD;
            end else begin
              drained_a <= 1'b1;
            end
          end else if (b_req) begin
            if (angles_left) begin
              lut_angle <= angle_cnt;
              req_is_b  <= 1'b1;
              state     <= LUT_RD;
            end else begin
              drained_b <= 1'b1;
            end
          end else if (drained_a & drained_b & ~a_sw_swap & ~b_sw_swap) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        LUT_RD: begin
          if (req_is_b) begin
            b_sh_accu_base <= lut_sh_accu_base;
            b_mp_accu_init <= lut_mp_accu_init;
            b_mp_accu_base <= lut_mp_accu_base;
            b_next_itr_ack <= 1'b1;
          end else begin
            a_sh_accu_base <= lut_sh_accu_base;
            a_mp_accu_init <= lut_mp_accu_init;
            a_mp_accu_base <= lut_mp_accu_base;
            a_next_itr_ack <= 1'b1;
          end
          state <= NEXT_ACK;
        end

        NEXT_ACK: begin
          // lut_angle is advanced together with the counter so the LUT's
          // registered read has already settled by the next LUT_RD.
          angle_cnt <= angle_cnt + 1'b1;
          lut_angle <= angle_cnt + 1'b1;
          state     <= RUN;
        end

        SWAP_ACK: state <= RUN;

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nabp_swap_control.sv
// tb_nabp_swap_control
//   Randomized self-checking bench for nabp_swap_control with four angles per
//   pass. A registered LUT with random contents is modelled here; expected
//   angle hand-out, ack latency, swap timing and pass completion come from a
//   transaction-level model of the controller's rules.
module tb_nabp_swap_control;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int SW = 16;
  localparam int IW = 16;
  localparam int BW = 16;
  localparam int TW = 64;

  logic          clk;
  logic          reset_n;
  logic          kick;
  logic          done;
  logic [AW-1:0] lut_angle;
  logic [SW-1:0] lut_sh_q;
  logic [IW-1:0] lut_mi_q;
  logic [BW-1:0] lut_mb_q;
  logic          a_sw_swap, b_sw_swap;
  logic          a_sw_next_itr, b_sw_next_itr;
  logic          a_sw_pe_en, b_sw_pe_en;
  logic [TW-1:0] a_pe_taps, b_pe_taps;
  logic [SW-1:0] a_sh_accu_base, b_sh_accu_base;
  logic [IW-1:0] a_mp_accu_init, b_mp_accu_init;
  logic [BW-1:0] a_mp_accu_base, b_mp_accu_base;
  logic          a_swap_ack, b_swap_ack;
  logic          a_next_itr_ack, b_next_itr_ack;
  logic          pe_en;
  logic [TW-1:0] pe_taps;

  nabp_swap_control #(
    .NO_OF_ANGLES(N),
    .ANGLE_W(AW),
    .SH_W(SW),
    .MI_W(IW),
    .MB_W(BW),
    .TAPS_W(TW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kick(kick),
    .done(done),
    .lut_angle(lut_angle),
    .lut_sh_accu_base(lut_sh_q),
    .lut_mp_accu_init(lut_mi_q),
    .lut_mp_accu_base(lut_mb_q),
    .a_sw_swap(a_sw_swap),
    .b_sw_swap(b_sw_swap),
    .a_sw_next_itr(a_sw_next_itr),
    .b_sw_next_itr(b_sw_next_itr),
    .a_sw_pe_en(a_sw_pe_en),
    .b_sw_pe_en(b_sw_pe_en),
    .a_pe_taps(a_pe_taps),
    .b_pe_taps(b_pe_taps),
    .a_sh_accu_base(a_sh_accu_base),
    .a_mp_accu_init(a_mp_accu_init),
    .a_mp_accu_base(a_mp_accu_base),
    .b_sh_accu_base(b_sh_accu_base),
    .b_mp_accu_init(b_mp_accu_init),
    .b_mp_accu_base(b_mp_accu_base),
    .a_swap_ack(a_swap_ack),
    .b_swap_ack(b_swap_ack),
    .a_next_itr_ack(a_next_itr_ack),
    .b_next_itr_ack(b_next_itr_ack),
    .pe_en(pe_en),
    .pe_taps(pe_taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator LUT: registered read, data one cycle after the address.
  logic [SW-1:0] lut_sh [256];
  logic [IW-1:0] lut_mi [256];
  logic [BW-1:0] lut_mb [256];

  always @(posedge clk) begin
    lut_sh_q <= lut_sh[lut_angle];
    lut_mi_q <= lut_mi[lut_angle];
    lut_mb_q <= lut_mb[lut_angle];
  end

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model state
  int exp_ang;
  bit drn_a, drn_b;
  bit exp_pe_b;
  int a_last, b_last;
  bit a_last_v, b_last_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a_bases(input string tag, input int ang);
    check({tag, "_a_sh"}, 64'(a_sh_accu_base), 64'(lut_sh[ang]));
    check({tag, "_a_mi"}, 64'(a_mp_accu_init), 64'(lut_mi[ang]));
    check({tag, "_a_mb"}, 64'(a_mp_accu_base), 64'(lut_mb[ang]));
  endtask

  task automatic check_b_bases(input string tag, input int ang);
    check({tag, "_b_sh"}, 64'(b_sh_accu_base), 64'(lut_sh[ang]));
    check({tag, "_b_mi"}, 64'(b_mp_accu_init), 64'(lut_mi[ang]));
    check({tag, "_b_mb"}, 64'(b_mp_accu_base), 64'(lut_mb[ang]));
  endtask

  // Called just after a rising edge with the controller in IDLE.
  task automatic kick_pass();
    kick = 1'b1;
    @(posedge clk); #1;
    kick     = 1'b0;
    exp_ang  = 0;
    drn_a    = 1'b0;
    drn_b    = 1'b0;
    exp_pe_b = 1'b1;
  endtask

  // Raise next_itr on the chosen units, each held until its ack, and check
  // angle order, bases, ack latency and ack count against the model.
  task automatic issue(input bit ra, input bit rb);
    bit want_a, want_b, drop_a, drop_b;
    int lat_a, lat_b, ang_a, ang_b, seen_a, seen_b;
    want_a = 1'b0; want_b = 1'b0;
    lat_a = 0; lat_b = 0; ang_a = 0; ang_b = 0; seen_a = 0; seen_b = 0;
    // A is served before B; the one served second waits for the first's
    // full request/ack cycle plus the return to RUN.
    if (ra && !drn_a) begin
      if (exp_ang < N) begin
        want_a = 1'b1; ang_a = exp_ang; exp_ang++; lat_a = 2;
      end else drn_a = 1'b1;
    end
    if (rb && !drn_b) begin
      if (exp_ang < N) begin
        want_b = 1'b1; ang_b = exp_ang; exp_ang++; lat_b = want_a ? 5 : 2;
      end else drn_b = 1'b1;
    end
    a_sw_next_itr = ra;
    b_sw_next_itr = rb;
    for (int c = 0; c < 10; c++) begin
      drop_a = 1'b0;
      drop_b = 1'b0;
      @(negedge clk);
      if (a_next_itr_ack) begin
        seen_a++;
        drop_a = 1'b1;
        if (want_a) begin
          check("a_ack_lat", 64'(c), 64'(lat_a));
          check_a_bases("a_ack", ang_a);
          a_last = ang_a; a_last_v = 1'b1;
        end
        if (b_last_v) check_b_bases("b_hold", b_last);
      end
      if (b_next_itr_ack) begin
        seen_b++;
        drop_b = 1'b1;
        if (want_b) begin
          check("b_ack_lat", 64'(c), 64'(lat_b));
          check_b_bases("b_ack", ang_b);
          b_last = ang_b; b_last_v = 1'b1;
        end
        if (a_last_v) check_a_bases("a_hold", a_last);
      end
      @(posedge clk); #1;
      if (drop_a) a_sw_next_itr = 1'b0;
      if (drop_b) b_sw_next_itr = 1'b0;
    end
    a_sw_next_itr = 1'b0;
    b_sw_next_itr = 1'b0;
    check("a_ack_cnt", 64'(seen_a), 64'(want_a));
    check("b_ack_cnt", 64'(seen_b), 64'(want_b));
  endtask

  // a_swap raised at cycle t, b_swap at t+5: both acks expected at t+6,
  // PE output switching to the other unit at t+7.
  task automatic swap_seq();
    logic [63:0] tap_a, tap_b, old_tap, new_tap;
    bit en_a, en_b, old_en, new_en;
    tap_a = {$urandom, $urandom};
    tap_b = {$urandom, $urandom};
    en_a  = 1'($urandom_range(0, 1));
    en_b  = ~en_a;
    a_pe_taps = tap_a; b_pe_taps = tap_b;
    a_sw_pe_en = en_a; b_sw_pe_en = en_b;
    old_tap = exp_pe_b ? tap_b : tap_a;
    new_tap = exp_pe_b ? tap_a : tap_b;
    old_en  = exp_pe_b ? en_b : en_a;
    new_en  = exp_pe_b ? en_a : en_b;
    @(posedge clk); #1;
    @(negedge clk);
    check("pe_taps_pre", pe_taps, old_tap);
    check("pe_en_pre", 64'(pe_en), 64'(old_en));
    @(posedge clk); #1;
    a_sw_swap = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("swap_ack_early", 64'({a_swap_ack, b_swap_ack}), 64'd0);
      @(posedge clk); #1;
    end
    b_sw_swap = 1'b1;
    @(negedge clk);
    check("swap_ack_early", 64'({a_swap_ack, b_swap_ack}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("swap_ack", 64'({a_swap_ack, b_swap_ack}), 64'd3);
    check("pe_taps_at_ack", pe_taps, old_tap);
    exp_pe_b = ~exp_pe_b;
    @(posedge clk); #1;
    a_sw_swap = 1'b0;
    b_sw_swap = 1'b0;
    @(negedge clk);
    check("swap_ack_after", 64'({a_swap_ack, b_swap_ack}), 64'd0);
    check("pe_taps_post", pe_taps, new_tap);
    check("pe_en_post", 64'(pe_en), 64'(new_en));
    @(posedge clk); #1;
  endtask

  int d0;
  int guard;
  int r;
  int held_lat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      lut_sh[i] = 16'($urandom);
      lut_mi[i] = 16'($urandom);
      lut_mb[i] = 16'($urandom);
    end
    reset_n = 1'b0;
    kick = 1'b0;
    a_sw_swap = 1'b0; b_sw_swap = 1'b0;
    a_sw_next_itr = 1'b0; b_sw_next_itr = 1'b0;
    a_sw_pe_en = 1'b1; b_sw_pe_en = 1'b1;
    a_pe_taps = {$urandom, $urandom};
    b_pe_taps = {$urandom, $urandom};
    a_last_v = 1'b0; b_last_v = 1'b0;
    a_last = 0; b_last = 0;
    exp_ang = 0; drn_a = 1'b0; drn_b = 1'b0; exp_pe_b = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_acks", 64'({a_swap_ack, b_swap_ack, a_next_itr_ack, b_next_itr_ack}), 64'd0);
    check("rst_pe_en", 64'(pe_en), 64'd0);
    check("rst_pe_taps", pe_taps, 64'd0);
    check("rst_lut_angle", 64'(lut_angle), 64'd0);
    check("rst_a_sh", 64'(a_sh_accu_base), 64'd0);
    check("rst_b_mb", 64'(b_mp_accu_base), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pe_en_idle", 64'(pe_en), 64'd0);
    @(posedge clk); #1;

    // Pass 1: alternating requesters, then drain and completion
    kick_pass();
    issue(1'b1, 1'b0);
    issue(1'b0, 1'b1);
    issue(1'b1, 1'b0);
    issue(1'b0, 1'b1);
    d0 = done_cnt;
    issue(1'b1, 1'b0);
    check("done_early", 64'(done_cnt - d0), 64'd0);
    issue(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("done_pulse", 64'(done_cnt - d0), 64'd1);
    a_sw_pe_en = 1'b1; b_sw_pe_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pe_en_idle_after_done", 64'(pe_en), 64'd0);
    @(posedge clk); #1;

    // Pass 2: simultaneous requests, ignored kick, swap, drain
    kick_pass();
    issue(1'b1, 1'b1);
    kick = 1'b1;
    @(posedge clk); #1;
    kick = 1'b0;
    issue(1'b0, 1'b1);
    swap_seq();
    d0 = done_cnt;
    issue(1'b1, 1'b1);
    issue(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("done_pass2", 64'(done_cnt - d0), 64'd1);
    @(posedge clk); #1;

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      d0 = done_cnt;
      kick_pass();
      guard = 0;
      while (!(drn_a && drn_b) && guard < 40) begin
        guard++;
        if (!drn_a && !drn_b && $urandom_range(0, 3) == 0) swap_seq();
        r = int'($urandom_range(0, 2));
        issue(r != 1, r != 0);
      end
      repeat (2) @(negedge clk);
      check("done_rand", 64'(done_cnt - d0), 64'd1);
      @(posedge clk); #1;
    end

    // Asynchronous reset while an ack is being presented
    kick_pass();
    a_sw_next_itr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_ack", 64'(a_next_itr_ack), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_acks", 64'({a_swap_ack, b_swap_ack, a_next_itr_ack, b_next_itr_ack}), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pe_en", 64'(pe_en), 64'd0);
    check("mid_rst_a_sh", 64'(a_sh_accu_base), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    a_last_v = 1'b0; b_last_v = 1'b0;
    // Held request must be ignored in IDLE, then served once kicked
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_ignore", 64'(a_next_itr_ack), 64'd0);
    end
    @(posedge clk); #1;
    kick_pass();
    held_lat = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_next_itr_ack && held_lat < 0) begin
        held_lat = c;
        check_a_bases("held_ack", 0);
      end
      @(posedge clk); #1;
      if (held_lat >= 0) a_sw_next_itr = 1'b0;
    end
    a_sw_next_itr = 1'b0;
    check("held_ack_lat", 64'(held_lat), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
